// File: rtl/tt_um_micro_gfg_development_pdm_cic_if.sv
// Pin bundle for the PDM CIC decimator: packed input pins and packed output pins.
interface tt_um_micro_gfg_development_pdm_cic_if;
    logic [7:0] ui_in;
    logic [7:0] uo_out;

    modport master (
        output ui_in,
        input  uo_out
    );

    modport slave (
        input  ui_in,
        output uo_out
    );
endinterface

// File: rtl/tt_um_micro_gfg_development_pdm_cic.sv
// Second-order CIC decimator turning a 1-bit PDM stream into 7-bit unsigned samples.
// Integrators run every enabled clock; the two comb stages are split over the
// frame-end edge (E) and the edge after it (E+1), which also strobes valid.
module tt_um_micro_gfg_development_pdm_cic (
    input  logic                                clk,
    input  logic                                rst_n,
    tt_um_micro_gfg_development_pdm_cic_if.slave bus
);
    localparam int unsigned W = 15;

    typedef enum logic {
        PH_INTEG,
        PH_COMB
    } phase_t;

    logic         pdm;
    logic [1:0]   rsel;
    logic         en;
    logic [3:0]   unused_ui;

    logic [1:0]   rsel_q;
    logic [6:0]   cnt;
    logic [6:0]   cnt_max;
    logic [2:0]   shamt;
    phase_t       phase;
    logic         run;
    logic         frame_end;

    logic [W-1:0] i1;
    logic [W-1:0] i2;
    logic [W-1:0] d1;
    logic [W-1:0] c1;
    logic [W-1:0] d2;
    logic [W-1:0] c2;
    logic [W-1:0] c2_shift;
    logic [6:0]   sample_next;

    logic [6:0]   sample;
    logic         valid;

    assign pdm       = bus.ui_in[0];
    assign rsel      = bus.ui_in[2:1];
    assign en        = bus.ui_in[3];
    assign unused_ui = bus.ui_in[7:4];

    // Decimation ratio and output shift (2k-7) from the latched select
    always_comb begin
        cnt_max = 7'd15;
        shamt   = 3'd1;
        case (rsel_q)
            2'b00: begin cnt_max = 7'd15;  shamt = 3'd1; end
            2'b01: begin cnt_max = 7'd31;  shamt = 3'd3; end
            2'b10: begin cnt_max = 7'd63;  shamt = 3'd5; end
            2'b11: begin cnt_max = 7'd127; shamt = 3'd7; end
            default: begin cnt_max = 7'd15; shamt = 3'd1; end
        endcase
    end

    // A pending E+1 step keeps the datapath running even if en has dropped
    assign run       = en || (phase == PH_COMB);
    assign frame_end = run && (cnt == cnt_max);

    // Second comb difference, scaling and saturation to 7 bits
    assign c2          = c1 - d2;
    assign c2_shift    = c2 >> shamt;
    assign sample_next = (|c2_shift[W-1:7]) ? 7'd127 : c2_shift[6:0];

    // Select register: follows rsel while disabled, otherwise only at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsel_q <= rsel;
        end else if (!en || frame_end) begin
            rsel_q <= rsel;
        end
    end

    // Clock-rate integrators, cleared while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1 <= '0;
            i2 <= '0;
        end else if (run) begin
            i1 <= i1 + {{(W-1){1'b0}}, pdm};
            i2 <= i2 + i1;
        end else begin
            i1 <= '0;
            i2 <= '0;
        end
    end

    // Frame counter, comb stages and registered output strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            phase  <= PH_INTEG;
            d1     <= '0;
            c1     <= '0;
            d2     <= '0;
            valid  <= 1'b0;
            sample <= '0;
        end else if (!run) begin
            cnt    <= '0;
            phase  <= PH_INTEG;
            d1     <= '0;
            c1     <= '0;
            d2     <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            cnt   <= frame_end ? 7'd0 : cnt + 7'd1;
            case (phase)
                PH_INTEG: begin
                    if (frame_end) begin
                        c1    <= i2 - d1;
                        d1    <= i2;
                        phase <= PH_COMB;
                    end
                end
                PH_COMB: begin
                    d2     <= c1;
                    sample <= sample_next;
                    valid  <= 1'b1;
                    phase  <= PH_INTEG;
                end
                default: phase <= PH_INTEG;
            endcase
        end
    end

    assign bus.uo_out = {valid, sample};
endmodule

// File: doc/tt_um_micro_gfg_development_pdm_cic.md
TT_UM_MICRO_GFG_DEVELOPMENT_PDM_CIC -- requirements
Module: tt_um_micro_gfg_development_pdm_cic

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port ui_in  input  8  bit0 = pdm (1-bit PDM data from the NCO stage); bits2:1 = rsel (decimation select); bit3 = en; bits7:4 unused and ignored.
REQ-004 SHALL have port uo_out  output  8  bits6:0 = sample (unsigned, 7 bits); bit7 = valid strobe.
REQ-005 SHALL decode rsel as 00->R=16 (k=4), 01->R=32 (k=5), 10->R=64 (k=6), 11->R=128 (k=7).

Function
REQ-006 SHALL implement a 2nd-order CIC decimator: two integrators at clock rate, decimate by R, two comb stages at output rate.
REQ-007 SHALL compute all integrator and comb arithmetic modulo 2^15 (15-bit registers I1, I2, D1, C1, D2; wrap-around is intentional, no saturation internally).
REQ-008 SHALL, each edge with en=1, update I1 <= I1 + pdm and I2 <= I2 + I1, with I2 using the pre-edge I1.
REQ-009 SHALL keep a 7-bit decimation counter cnt counting 0..R-1; it wraps to 0 on the edge where cnt==R-1 (event "E").
REQ-010 SHALL, on edge E, update C1 <= I2 - D1 and D1 <= I2, using the pre-edge I2, and set an internal phase flag.
REQ-011 SHALL, on the edge after E (E+1), compute C2 = C1 - D2, update D2 <= C1, and register sample <= min(C2 >> (2k-7), 127).
REQ-012 SHALL drive valid high for exactly the one clock cycle following edge E+1; otherwise valid is low, so one valid pulse occurs every R cycles.
REQ-013 SHALL hold sample stable between valid pulses.
REQ-014 SHALL produce exactly C2 = R^2 in steady state for constant pdm=1, giving sample 127 (saturated), for every R.
REQ-015 SHALL produce C2 = 0 in steady state for constant pdm=0, giving sample 0.
REQ-016 SHALL produce C2 = R^2/2 in steady state for alternating pdm (1010...), giving sample 64, for every R.
REQ-017 SHALL latch rsel into an internal register rsel_q only on edge E or while en=0; cnt limit, shift amount k, and saturation use rsel_q only.
REQ-018 SHALL, when rsel changes mid-frame, complete the current frame at the old R and apply the new R from the next frame.
REQ-019 SHALL treat the first two valid samples after reset, after en rising, or after an rsel_q change as transients; these are flagged valid and carry unspecified values.
REQ-020 SHALL, while en=0, synchronously clear I1, I2, D1, C1, D2, cnt, the phase flag and valid; sample holds its last value.
REQ-021 SHALL ignore en=0 while the phase flag is set: the E+1 step completes before the clear takes effect.
REQ-022 SHALL have no other outputs; uo_out is fully registered with no combinational path from ui_in.

Reset
REQ-023 SHALL, while rst_n=0, asynchronously force I1, I2, D1, C1, D2, cnt, phase flag, valid and sample to 0, and rsel_q to the current rsel.
REQ-024 SHALL begin counting from cnt=0 on the first rising edge after rst_n deasserts; assertion of rst_n mid-frame aborts the frame and emits no valid pulse.

Verification
REQ-025 Reset, en=1, rsel=00, pdm=1 constant -> first valid after edge 17, then every 16 cycles; from the 3rd valid onward sample=127.
REQ-026 en=1, rsel=10, pdm alternating 1,0 -> valid every 64 cycles; from the 3rd valid onward sample=64, internal C2=2048.
REQ-027 en=1, rsel=11, pdm=0 for 1000 cycles -> all valids carry sample=0; no valid when en is dropped to 0 for 10 cycles; sample holds; counting restarts at cnt=0.
REQ-028 rsel switched 00->11 mid-frame with pdm=1 -> the current 16-cycle frame completes, then the valid period becomes 128; after 2 transient valids sample=127.
REQ-029 Run with pdm=1, rsel=11 for 5000 cycles so that I1 and I2 wrap modulo 2^15 -> sample stays 127 on every non-transient valid (wrap-around invisible at the output).
REQ-030 rst_n pulsed low for 1 cycle at cnt=50 (R=64) -> uo_out=0 immediately (asynchronous); first valid occurs 65 cycles after release.
